// File: rtl/audio_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | audio_pkg : shared types and widths for the audio sample prefetcher |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
package audio_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int SDRAM_ADDR_W = 25;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | sample_fifo : DEPTH x SAMPLE_W synchronous FIFO, read-before-write  |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     AudioClk,
    input  logic                     Reset,
    input  logic                     push_i,
    input  logic [SAMPLE_W-1:0]      wdata_i,
    input  logic                     pop_i,
    output logic [SAMPLE_W-1:0]      rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [AW:0]         wptr_q;
    logic [AW:0]         rptr_q;
    logic [AW:0]         w_count;
    logic                w_push;
    logic                w_pop;

    assign w_count = wptr_q - rptr_q;
    assign full_o  = (w_count == (AW+1)'(DEPTH));
    assign empty_o = (w_count == '0);
    assign count_o = w_count;
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    // Head is read straight from storage, so a same-cycle push never disturbs it.
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge AudioClk) begin
        if (w_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge AudioClk or posedge Reset) begin
        if (Reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/audio_sample_prefetch.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | audio_sample_prefetch : SDRAM read sequencer + sample FIFO feeding   |
// | the I2S serializer one sample per LRClk edge.  Rev 1.0               |
// +---------------------------------------------------------------------+
module audio_sample_prefetch
    import audio_pkg::*;
#(
    parameter int                DEPTH      = 8,
    parameter int                ADDR_W     = SDRAM_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(25'h1FF_FFFF)
) (
    input  logic                   AudioClk,
    input  logic                   Reset,
    input  logic                   Play,
    input  logic                   LRClk,
    output logic                   rd_cmd,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic                   rd_done,
    input  logic [SAMPLE_W-1:0]    rd_data,
    output logic [SAMPLE_W-1:0]    sample_out,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] fill
);

    logic [2:0]          lr_sync_q;
    logic [1:0]          done_sync_q;
    fetch_state_t        state_q;
    logic                rd_cmd_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [SAMPLE_W-1:0] sample_out_q;
    logic                underrun_q;

    logic                w_done_s;
    logic                w_pop_evt;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    logic [SAMPLE_W-1:0] w_head;
    logic [ADDR_W-1:0]   w_next_addr;

    // Two-flop synchronizers; the third LRClk flop provides the edge reference.
    always_ff @(posedge AudioClk or posedge Reset) begin
        if (Reset) begin
            lr_sync_q   <= '0;
            done_sync_q <= '0;
        end else begin
            lr_sync_q   <= {lr_sync_q[1:0], LRClk};
            done_sync_q <= {done_sync_q[0], rd_done};
        end
    end

    assign w_done_s    = done_sync_q[1];
    assign w_pop_evt   = (lr_sync_q[1] ^ lr_sync_q[2]) & Play;
    assign w_push      = (state_q == REQ) & w_done_s;
    assign w_next_addr = (rd_addr_q == END_ADDR) ? START_ADDR : rd_addr_q + 1'b1;

    always_ff @(posedge AudioClk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            rd_cmd_q  <= 1'b0;
            rd_addr_q <= START_ADDR;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Play && !w_full) begin
                        state_q  <= REQ;
                        rd_cmd_q <= 1'b1;
                    end
                end
                REQ: begin
                    // Completes even when Play has dropped so the data is kept.
                    if (w_done_s) begin
                        state_q   <= RELEASE;
                        rd_cmd_q  <= 1'b0;
                        rd_addr_q <= w_next_addr;
                    end
                end
                RELEASE: begin
                    if (!w_done_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    rd_cmd_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge AudioClk or posedge Reset) begin
        if (Reset) begin
            sample_out_q <= '0;
            underrun_q   <= 1'b0;
        end else if (!Play) begin
            sample_out_q <= '0;
        end else if (w_pop_evt) begin
            if (w_empty) begin
                sample_out_q <= '0;
                underrun_q   <= 1'b1;
            end else begin
                sample_out_q <= w_head;
            end
        end
    end

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .AudioClk (AudioClk),
        .Reset    (Reset),
        .push_i   (w_push),
        .wdata_i  (rd_data),
        .pop_i    (w_pop_evt),
        .rdata_o  (w_head),
        .full_o   (w_full),
        .empty_o  (w_empty),
        .count_o  (fill)
    );

    assign rd_cmd     = rd_cmd_q;
    assign rd_addr    = rd_addr_q;
    assign sample_out = sample_out_q;
    assign underrun   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_prefetch.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_audio_sample_prefetch : directed bench with an SDRAM responder    |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module tb_audio_sample_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        play, play2;
    logic        lr, lr2;
    logic        stall;

    logic        rd_cmd, rd_cmd2;
    logic [24:0] rd_addr, rd_addr2;
    logic        rd_done, rd_done2;
    logic [15:0] rd_data, rd_data2;
    logic [15:0] sample_out, sample_out2;
    logic        underrun, underrun2;
    logic [3:0]  fill, fill2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [24:0] log1 [0:255];
    logic [24:0] log2 [0:255];
    int          n_req1 = 0;
    int          n_req2 = 0;
    int          cnt1, cnt2;
    logic        prev1, prev2;

    always #5 clk = ~clk;

    audio_sample_prefetch dut (
        .AudioClk   (clk),
        .Reset      (rst),
        .Play       (play),
        .LRClk      (lr),
        .rd_cmd     (rd_cmd),
        .rd_addr    (rd_addr),
        .rd_done    (rd_done),
        .rd_data    (rd_data),
        .sample_out (sample_out),
        .underrun   (underrun),
        .fill       (fill)
    );

    audio_sample_prefetch #(
        .START_ADDR (25'h10),
        .END_ADDR   (25'h12)
    ) dut_wrap (
        .AudioClk   (clk),
        .Reset      (rst),
        .Play       (play2),
        .LRClk      (lr2),
        .rd_cmd     (rd_cmd2),
        .rd_addr    (rd_addr2),
        .rd_done    (rd_done2),
        .rd_data    (rd_data2),
        .sample_out (sample_out2),
        .underrun   (underrun2),
        .fill       (fill2)
    );

    // SDRAM responder: acknowledges 5 cycles after rd_cmd with data = address[15:0].
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt1 <= 0; rd_done <= 1'b0; rd_data <= '0; prev1 <= 1'b0;
        end else begin
            prev1 <= rd_cmd;
            if (rd_cmd && !prev1 && n_req1 < 256) begin
                log1[n_req1] <= rd_addr;
                n_req1       <= n_req1 + 1;
            end
            if (rd_done) begin
                if (!rd_cmd) rd_done <= 1'b0;
            end else if (rd_cmd && !stall) begin
                if (cnt1 == 4) begin
                    rd_done <= 1'b1; rd_data <= rd_addr[15:0]; cnt1 <= 0;
                end else begin
                    cnt1 <= cnt1 + 1;
                end
            end else begin
                cnt1 <= 0;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt2 <= 0; rd_done2 <= 1'b0; rd_data2 <= '0; prev2 <= 1'b0;
        end else begin
            prev2 <= rd_cmd2;
            if (rd_cmd2 && !prev2 && n_req2 < 256) begin
                log2[n_req2] <= rd_addr2;
                n_req2       <= n_req2 + 1;
            end
            if (rd_done2) begin
                if (!rd_cmd2) rd_done2 <= 1'b0;
            end else if (rd_cmd2) begin
                if (cnt2 == 4) begin
                    rd_done2 <= 1'b1; rd_data2 <= rd_addr2[15:0]; cnt2 <= 0;
                end else begin
                    cnt2 <= cnt2 + 1;
                end
            end else begin
                cnt2 <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fill(input logic [31:0] target, input int limit, input string tag);
        int k = 0;
        while ({28'd0, fill} !== target && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, fill, target);
    endtask

    // Toggle LRClk, confirm sample_out holds for 2 edges and updates on the 3rd.
    task automatic pop_check(input string tag, input logic [31:0] prev, input logic [31:0] exp);
        @(negedge clk);
        lr = ~lr;
        @(posedge clk);
        @(posedge clk);
        #1;
        check({tag, "_hold"}, sample_out, prev);
        @(posedge clk);
        #1;
        check(tag, sample_out, exp);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_exp [0:4];
        int          base;
        int          k;
        wrap_exp[0] = 32'h10; wrap_exp[1] = 32'h11; wrap_exp[2] = 32'h12;
        wrap_exp[3] = 32'h10; wrap_exp[4] = 32'h11;

        rst = 1'b1; play = 1'b0; play2 = 1'b0; lr = 1'b0; lr2 = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_cmd", rd_cmd, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_sample_out", sample_out, 0);
        check("rst_underrun", underrun, 0);
        check("rst_fill", fill, 0);

        // Fill from address 0 until full.
        rst = 1'b0; play = 1'b1; play2 = 1'b1;
        wait_fill(8, 400, "fill_to_8");
        repeat (40) @(negedge clk);
        check("req_count_full", n_req1, 8);
        check("rd_cmd_while_full", rd_cmd, 0);
        check("rd_addr_after_fill", rd_addr, 8);
        for (int i = 0; i < 8; i++) check("addr_seq", log1[i], i);
        check("wrap_req_count", (n_req2 >= 5), 1);
        for (int i = 0; i < 5; i++) check("wrap_addr_seq", log2[i], wrap_exp[i]);

        // Pops from a full FIFO with refetch.
        for (int i = 0; i < 4; i++) begin
            pop_check("pop_full", (i == 0) ? 0 : i - 1, i);
            check("fill_after_pop", fill, 7);
            wait_fill(8, 100, "refill");
        end
        check("req_count_refill", n_req1, 12);

        // Stall the SDRAM and drain into underrun.
        stall = 1'b1;
        for (int i = 0; i < 8; i++) pop_check("pop_drain", 3 + i, 4 + i);
        check("fill_drained", fill, 0);
        check("no_underrun_yet", underrun, 0);
        pop_check("pop_underrun", 11, 0);
        check("underrun_set", underrun, 1);
        pop_check("pop_after_underrun", 0, 0);
        check("underrun_sticky", underrun, 1);

        // Pause while a request is in flight.
        check("stalled_req", rd_cmd, 1);
        play = 1'b0; stall = 1'b0;
        wait_fill(1, 100, "inflight_push");
        repeat (30) @(negedge clk);
        check("paused_rd_cmd", rd_cmd, 0);
        check("paused_rd_addr", rd_addr, 13);
        check("paused_fill", fill, 1);
        check("paused_sample", sample_out, 0);
        lr = ~lr;
        repeat (6) @(negedge clk);
        check("paused_pop_fill", fill, 1);
        check("paused_pop_sample", sample_out, 0);

        play = 1'b1;
        pop_check("resume_pop", 0, 12);
        wait_fill(8, 400, "resume_fill");
        check("resume_rd_addr", rd_addr, 21);
        @(negedge clk);
        play = 1'b0;
        @(posedge clk);
        #1;
        check("pause_zero", sample_out, 0);
        check("underrun_through_pause", underrun, 1);

        // Reset with a request outstanding and fill=5.
        @(negedge clk);
        play = 1'b1; stall = 1'b1;
        pop_check("pre_rst_pop", 0, 13);
        pop_check("pre_rst_pop", 13, 14);
        pop_check("pre_rst_pop", 14, 15);
        check("pre_rst_fill", fill, 5);
        check("pre_rst_rd_cmd", rd_cmd, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rd_cmd", rd_cmd, 0);
        check("async_rst_rd_addr", rd_addr, 0);
        check("async_rst_sample", sample_out, 0);
        check("async_rst_underrun", underrun, 0);
        check("async_rst_fill", fill, 0);
        repeat (2) @(negedge clk);
        base  = n_req1;
        stall = 1'b0;
        rst   = 1'b0;
        k = 0;
        while (n_req1 == base && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("post_rst_req_seen", (n_req1 > base), 1);
        check("post_rst_addr", log1[base], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
